cpu0_mem_arbiter: RTL and testbench

- Shares the single memory0 port (en/rw/size/mar/mdr/dbus) between two bus masters: rq0 (cpu0 core) and rq1 (DMA/loader engine).
- Sequences each access as arbitrate → access → capture.
- Decodes the memory-mapped output port at IOADDR into a separate io strobe, so IO never touches memory.
- Flags accesses outside the memory window.

---
 rtl/cpu0_mem_pkg.sv | 42 ++++
 rtl/cpu0_rr_pick.sv | 20 ++
 rtl/cpu0_mem_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_cpu0_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu0_mem_pkg.sv
// cpu0_mem_pkg: types and defaults shared by the cpu0 memory arbiter.
//   size_t  : access size encoding on rq*_size / m_size / io_size
//   state_t : arbiter sequencing states
//   win_t   : address window class of a latched request
//   classify: maps a byte address onto its window class
package cpu0_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_INT16 = 2'b01,
        SZ_INT24 = 2'b10,
        SZ_INT32 = 2'b11
    } size_t;

    localparam logic [31:0] DEF_MEMSIZE = 32'h0008_0000;
    localparam logic [31:0] DEF_IOADDR  = 32'h0008_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        WIN_MEM = 2'd0,
        WIN_IO  = 2'd1,
        WIN_BAD = 2'd2
    } win_t;

    // Memory wins over IO if the two windows ever overlap; size is ignored.
    function automatic win_t classify(input logic [31:0] addr,
                                      input logic [31:0] memsize,
                                      input logic [31:0] ioaddr);
        if (addr <= memsize - 32'd4) begin
            return WIN_MEM;
        end else if (addr == ioaddr) begin
            return WIN_IO;
        end
        return WIN_BAD;
    endfunction

endpackage

// File: rtl/cpu0_rr_pick.sv
// cpu0_rr_pick: two-way request picker.
//   req   in  2  request bits, bit 0 = rq0, bit 1 = rq1
//   ptr   in  1  0 = rq0 favoured on a tie, 1 = rq1 favoured
//   fixed in  1  1 = rq0 always wins a tie, ptr ignored
//   win   out 2  one-hot winner, 00 when nothing requests
module cpu0_rr_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       fixed,
    output logic [1:0] win
);

    always_comb begin
        win = req;
        if (req == 2'b11) begin
            win = (fixed || !ptr) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/cpu0_mem_arbiter.sv
// cpu0_mem_arbiter: shares the memory0 port between rq0 (cpu0 core) and
// rq1 (DMA/loader), decodes the IO port at IOADDR and flags accesses
// outside the memory window.
//   clock, reset        : rising-edge clock, async active-low reset
//   rq*_req/rw/size/addr/wdata -> requester inputs (req held until ack)
//   rq*_gnt/ack/rdata   : grant pulse, completion pulse, read data
//   m_en/m_rw/m_size/mar/mdr, dbus : memory0 port
//   io_wr/io_data/io_size : IO port write strobe and payload
//   err                 : out-of-window pulse, coincident with ack
// Build option: CPU0_ARB_FIXED_PRIO_EN gives rq0 fixed priority on ties
// instead of round robin.
//
// state     | meaning
// ST_IDLE   | waiting for a request; winner latched and granted on exit
// ST_ACCESS | memory outputs held stable for HOLD_CYCLES cycles
// ST_DONE   | dbus captured, ack (and err) issued on exit
module cpu0_mem_arbiter
    import cpu0_mem_pkg::*;
#(
    parameter logic [31:0] MEMSIZE     = DEF_MEMSIZE,
    parameter logic [31:0] IOADDR      = DEF_IOADDR,
    parameter int          HOLD_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rq0_req,
    input  logic        rq0_rw,
    input  logic [1:0]  rq0_size,
    input  logic [31:0] rq0_addr,
    input  logic [31:0] rq0_wdata,
    output logic        rq0_gnt,
    output logic        rq0_ack,
    output logic [31:0] rq0_rdata,
    input  logic        rq1_req,
    input  logic        rq1_rw,
    input  logic [1:0]  rq1_size,
    input  logic [31:0] rq1_addr,
    input  logic [31:0] rq1_wdata,
    output logic        rq1_gnt,
    output logic        rq1_ack,
    output logic [31:0] rq1_rdata,
    output logic        m_en,
    output logic        m_rw,
    output logic [1:0]  m_size,
    output logic [31:0] mar,
    output logic [31:0] mdr,
    input  logic [31:0] dbus,
    output logic        io_wr,
    output logic [31:0] io_data,
    output logic [1:0]  io_size,
    output logic        err
);

    localparam logic [2:0] HOLD = 3'(HOLD_CYCLES);

    state_t      state, state_nxt;
    win_t        cls, sel_cls;
    size_t       sel_size;
    logic [2:0]  cnt;
    logic [1:0]  pick;
    logic        ptr, cur, l_rw, fixed, take, finish, sel_rw;
    logic [31:0] sel_addr, sel_wdata, rd_val;

`ifdef CPU0_ARB_FIXED_PRIO_EN
    assign fixed = 1'b1;
`else
    assign fixed = 1'b0;
`endif

    cpu0_rr_pick u_pick (
        .req   ({rq1_req, rq0_req}),
        .ptr   (ptr),
        .fixed (fixed),
        .win   (pick)
    );

    assign sel_rw    = pick[1] ? rq1_rw    : rq0_rw;
    assign sel_size  = size_t'(pick[1] ? rq1_size : rq0_size);
    assign sel_addr  = pick[1] ? rq1_addr  : rq0_addr;
    assign sel_wdata = pick[1] ? rq1_wdata : rq0_wdata;
    assign sel_cls   = classify(sel_addr, MEMSIZE, IOADDR);
    assign rd_val    = (cls == WIN_MEM && l_rw) ? dbus : 32'd0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|pick) begin
                    state_nxt = ST_ACCESS;
                    take      = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (cnt == HOLD) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                finish    = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr       <= 1'b0;
            cur       <= 1'b0;
            l_rw      <= 1'b0;
            cls       <= WIN_MEM;
            cnt       <= 3'd0;
            rq0_gnt   <= 1'b0;
            rq1_gnt   <= 1'b0;
            rq0_ack   <= 1'b0;
            rq1_ack   <= 1'b0;
            rq0_rdata <= 32'd0;
            rq1_rdata <= 32'd0;
            m_en      <= 1'b0;
            m_rw      <= 1'b0;
            m_size    <= 2'b00;
            mar       <= 32'd0;
            mdr       <= 32'd0;
            io_wr     <= 1'b0;
            io_data   <= 32'd0;
            io_size   <= 2'b00;
            err       <= 1'b0;
        end else begin
            rq0_gnt <= 1'b0;
            rq1_gnt <= 1'b0;
            rq0_ack <= 1'b0;
            rq1_ack <= 1'b0;
            io_wr   <= 1'b0;
            err     <= 1'b0;
            if (take) begin
                rq0_gnt <= pick[0];
                rq1_gnt <= pick[1];
                cur     <= pick[1];
                // pointer moves to whichever master did not win
                ptr     <= pick[0];
                l_rw    <= sel_rw;
                cls     <= sel_cls;
                cnt     <= 3'd1;
                if (sel_cls == WIN_MEM) begin
                    m_en   <= 1'b1;
                    m_rw   <= sel_rw;
                    m_size <= sel_size;
                    mar    <= sel_addr;
                    mdr    <= sel_wdata;
                end
                if (sel_cls == WIN_IO && !sel_rw) begin
                    io_wr   <= 1'b1;
                    io_data <= sel_wdata;
                    io_size <= sel_size;
                end
            end
            if (state == ST_ACCESS) begin
                cnt <= cnt + 3'd1;
                if (state_nxt == ST_DONE) begin
                    m_en <= 1'b0;
                end
            end
            if (finish) begin
                m_en <= 1'b0;
                err  <= (cls == WIN_BAD);
                if (cur) begin
                    rq1_ack <= 1'b1;
                end else begin
                    rq0_ack <= 1'b1;
                end
                // writes to memory or the IO port leave rdata untouched
                if (l_rw || cls == WIN_BAD) begin
                    if (cur) begin
                        rq1_rdata <= rd_val;
                    end else begin
                        rq0_rdata <= rd_val;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu0_mem_arbiter.sv
// Testbench for cpu0_mem_arbiter. Instance u_dut runs with HOLD_CYCLES=1,
// instance u_hold with HOLD_CYCLES=3 (rq1 tied off). A behavioural model
// (round-robin favour bit, address window arithmetic, word memory) predicts
// grants, acks, errors and read data.
module tb_cpu0_mem_arbiter;

    localparam logic [31:0] TB_MEMSIZE = 32'h0008_0000;
    localparam logic [31:0] TB_IOADDR  = 32'h0008_0000;
    localparam int C_MEM = 0;
    localparam int C_IO  = 1;
    localparam int C_BAD = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        rq0_req, rq1_req, rq0_rw, rq1_rw;
    logic [1:0]  rq0_size, rq1_size;
    logic [31:0] rq0_addr, rq1_addr, rq0_wdata, rq1_wdata, dbus;
    logic        rq0_gnt, rq1_gnt, rq0_ack, rq1_ack, m_en, m_rw, io_wr, err;
    logic [1:0]  m_size, io_size;
    logic [31:0] rq0_rdata, rq1_rdata, mar, mdr, io_data;

    logic        b_req0, b_zero1;
    logic [1:0]  b_zero2;
    logic [31:0] b_zero32, b_dbus;
    logic        b_gnt0, b_gnt1, b_ack0, b_ack1, b_m_en, b_m_rw, b_io_wr, b_err;
    logic [1:0]  b_m_size, b_io_size;
    logic [31:0] b_rdata0, b_rdata1, b_mar, b_mdr, b_io_data;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem_env [logic [31:0]];
    logic [31:0] mem_ref [logic [31:0]];
    bit          t_rw   [2];
    logic [1:0]  t_sz   [2];
    logic [31:0] t_addr [2];
    logic [31:0] t_wd   [2];
    bit          pend   [2];
    logic [31:0] rd_exp [2];
    bit          ptr_m;

    always #5 clock = ~clock;

    cpu0_mem_arbiter #(.MEMSIZE(TB_MEMSIZE), .IOADDR(TB_IOADDR), .HOLD_CYCLES(1)) u_dut (
        .clock(clock), .reset(reset),
        .rq0_req(rq0_req), .rq0_rw(rq0_rw), .rq0_size(rq0_size), .rq0_addr(rq0_addr),
        .rq0_wdata(rq0_wdata), .rq0_gnt(rq0_gnt), .rq0_ack(rq0_ack), .rq0_rdata(rq0_rdata),
        .rq1_req(rq1_req), .rq1_rw(rq1_rw), .rq1_size(rq1_size), .rq1_addr(rq1_addr),
        .rq1_wdata(rq1_wdata), .rq1_gnt(rq1_gnt), .rq1_ack(rq1_ack), .rq1_rdata(rq1_rdata),
        .m_en(m_en), .m_rw(m_rw), .m_size(m_size), .mar(mar), .mdr(mdr), .dbus(dbus),
        .io_wr(io_wr), .io_data(io_data), .io_size(io_size), .err(err)
    );

    cpu0_mem_arbiter #(.MEMSIZE(TB_MEMSIZE), .IOADDR(TB_IOADDR), .HOLD_CYCLES(3)) u_hold (
        .clock(clock), .reset(reset),
        .rq0_req(b_req0), .rq0_rw(rq0_rw), .rq0_size(rq0_size), .rq0_addr(rq0_addr),
        .rq0_wdata(rq0_wdata), .rq0_gnt(b_gnt0), .rq0_ack(b_ack0), .rq0_rdata(b_rdata0),
        .rq1_req(b_zero1), .rq1_rw(b_zero1), .rq1_size(b_zero2), .rq1_addr(b_zero32),
        .rq1_wdata(b_zero32), .rq1_gnt(b_gnt1), .rq1_ack(b_ack1), .rq1_rdata(b_rdata1),
        .m_en(b_m_en), .m_rw(b_m_rw), .m_size(b_m_size), .mar(b_mar), .mdr(b_mdr), .dbus(b_dbus),
        .io_wr(b_io_wr), .io_data(b_io_data), .io_size(b_io_size), .err(b_err)
    );

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] env_rd(input logic [31:0] a);
        return mem_env.exists(a) ? mem_env[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return mem_ref.exists(a) ? mem_ref[a] : dflt(a);
    endfunction

    // memory0 environment: combinational-ish read refreshed each negedge, write on enable
    always @(negedge clock) begin
        dbus   = env_rd(mar);
        b_dbus = env_rd(b_mar);
    end
    always @(posedge clock) begin
        if (m_en === 1'b1 && m_rw === 1'b0) mem_env[mar] = mdr;
    end

    function automatic int wclass(input logic [31:0] a);
        if (longint'(a) + 64'd4 <= longint'(TB_MEMSIZE)) return C_MEM;
        if (a == TB_IOADDR) return C_IO;
        return C_BAD;
    endfunction

    function automatic int predict();
        if (pend[0] && pend[1]) begin
`ifdef CPU0_ARB_FIXED_PRIO_EN
            return 0;
`else
            return ptr_m ? 1 : 0;
`endif
        end
        return pend[0] ? 0 : 1;
    endfunction

    function automatic logic [31:0] gnt_of(input int m);
        return {31'b0, (m == 1) ? rq1_gnt : rq0_gnt};
    endfunction
    function automatic logic [31:0] ack_of(input int m);
        return {31'b0, (m == 1) ? rq1_ack : rq0_ack};
    endfunction
    function automatic logic [31:0] rdata_of(input int m);
        return (m == 1) ? rq1_rdata : rq0_rdata;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0: return 32'h0007_FFFC;
            1: return TB_IOADDR;
            2: return 32'h0007_FFFD;
            3: return 32'h0009_0000;
            4: return $urandom();
            default: return 32'($urandom_range(0, 15)) * 32'd4 + 32'h200;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int m, input bit rw, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
        t_rw[m] = rw; t_sz[m] = sz; t_addr[m] = a; t_wd[m] = wd; pend[m] = 1'b1;
        if (m == 0) begin
            rq0_req = 1'b1; rq0_rw = rw; rq0_size = sz; rq0_addr = a; rq0_wdata = wd;
        end else begin
            rq1_req = 1'b1; rq1_rw = rw; rq1_size = sz; rq1_addr = a; rq1_wdata = wd;
        end
    endtask

    task automatic drop(input int m);
        pend[m] = 1'b0;
        if (m == 0) rq0_req = 1'b0;
        else        rq1_req = 1'b0;
    endtask

    // Called at a negedge with the arbiter idle; follows one transaction to its ack.
    task automatic serve(input int w);
        int o, c;
        bit io_write;
        o = 1 - w;
        c = wclass(t_addr[w]);
        io_write = (c == C_IO) && !t_rw[w];
        @(negedge clock);
        check("gnt_winner", gnt_of(w), 32'd1);
        check("gnt_other", gnt_of(o), 32'd0);
        check("m_en_access", 32'(m_en), 32'(c == C_MEM));
        if (c == C_MEM) begin
            check("mar", mar, t_addr[w]);
            check("m_size", 32'(m_size), 32'(t_sz[w]));
            check("m_rw", 32'(m_rw), 32'(t_rw[w]));
            if (!t_rw[w]) check("mdr", mdr, t_wd[w]);
        end
        check("io_wr", 32'(io_wr), 32'(io_write));
        if (io_write) begin
            check("io_data", io_data, t_wd[w]);
            check("io_size", 32'(io_size), 32'(t_sz[w]));
        end
        @(negedge clock);
        check("m_en_done", 32'(m_en), 32'd0);
        check("ack_early", ack_of(w), 32'd0);
        check("io_wr_pulse", 32'(io_wr), 32'd0);
        @(negedge clock);
        if (t_rw[w])           rd_exp[w] = (c == C_MEM) ? ref_rd(t_addr[w]) : 32'd0;
        else if (c == C_BAD)   rd_exp[w] = 32'd0;
        else if (c == C_MEM)   mem_ref[t_addr[w]] = t_wd[w];
        check("ack", ack_of(w), 32'd1);
        check("ack_other", ack_of(o), 32'd0);
        check("err", 32'(err), 32'(c == C_BAD));
        check("rdata", rdata_of(w), rd_exp[w]);
        check("rdata_other", rdata_of(o), rd_exp[o]);
        check("m_en_idle", 32'(m_en), 32'd0);
        ptr_m = (w == 0);
        drop(w);
    endtask

    task automatic drain();
        while (pend[0] || pend[1]) serve(predict());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        rq0_req = 1'b0; rq0_rw = 1'b0; rq0_size = 2'b00; rq0_addr = 32'd0; rq0_wdata = 32'd0;
        rq1_req = 1'b0; rq1_rw = 1'b0; rq1_size = 2'b00; rq1_addr = 32'd0; rq1_wdata = 32'd0;
        dbus = 32'd0; b_dbus = 32'd0;
        b_req0 = 1'b0; b_zero1 = 1'b0; b_zero2 = 2'b00; b_zero32 = 32'd0;
        pend[0] = 1'b0; pend[1] = 1'b0; rd_exp[0] = 32'd0; rd_exp[1] = 32'd0; ptr_m = 1'b0;
        mem_env[32'h100] = 32'h1234_5678;
        mem_ref[32'h100] = 32'h1234_5678;

        repeat (2) @(negedge clock);
        check("rst_m_en", 32'(m_en), 32'd0);
        check("rst_m_rw", 32'(m_rw), 32'd0);
        check("rst_m_size", 32'(m_size), 32'd0);
        check("rst_mar", mar, 32'd0);
        check("rst_mdr", mdr, 32'd0);
        check("rst_rdata0", rq0_rdata, 32'd0);
        check("rst_rdata1", rq1_rdata, 32'd0);
        check("rst_io", {io_data[29:0], io_wr, err}, 32'd0);
        check("rst_handshake", {28'd0, rq0_gnt, rq1_gnt, rq0_ack, rq1_ack}, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // single INT32 read of preloaded word
        set_req(0, 1'b1, 2'b11, 32'h100, 32'd0);
        drain();

        // both masters write together, four rounds
        for (int r = 0; r < 4; r++) begin
            set_req(0, 1'b0, 2'b11, 32'h10 + 32'(r) * 32'd8, 32'hA000_0000 + 32'(r));
            set_req(1, 1'b0, 2'b01, 32'h14 + 32'(r) * 32'd8, 32'hB000_0000 + 32'(r));
            drain();
        end

        // IO write, then window edges
        set_req(1, 1'b0, 2'b11, 32'h0008_0000, 32'h0000_0A41);
        drain();
        set_req(0, 1'b1, 2'b11, 32'h0007_FFFC, 32'd0);
        drain();
        set_req(0, 1'b1, 2'b11, 32'h0009_0000, 32'd0);
        drain();
        set_req(0, 1'b1, 2'b00, 32'h0007_FFFD, 32'd0);
        drain();

        // reset during ACCESS of an rq1 write, rq0 pending
        set_req(1, 1'b0, 2'b11, 32'h40, 32'hDEAD_BEEF);
        @(negedge clock);
        check("abort_gnt1", gnt_of(1), 32'd1);
        check("abort_m_en_pre", 32'(m_en), 32'd1);
        set_req(0, 1'b1, 2'b11, 32'h100, 32'd0);
        reset = 1'b0;
        #1;
        check("abort_m_en", 32'(m_en), 32'd0);
        @(negedge clock);
        check("abort_no_ack", ack_of(1), 32'd0);
        check("abort_no_io", 32'(io_wr), 32'd0);
        reset = 1'b1;
        ptr_m = 1'b0; rd_exp[0] = 32'd0; rd_exp[1] = 32'd0;
        drain();

        // HOLD_CYCLES=3 instance, req dropped right after grant
        rq0_rw = 1'b1; rq0_size = 2'b11; rq0_addr = 32'h100; rq0_wdata = 32'd0;
        b_req0 = 1'b1;
        @(negedge clock);
        check("hold_gnt", 32'(b_gnt0), 32'd1);
        check("hold_m_en0", 32'(b_m_en), 32'd1);
        b_req0 = 1'b0;
        for (int k = 1; k < 3; k++) begin
            @(negedge clock);
            check("hold_m_en", 32'(b_m_en), 32'd1);
            check("hold_no_ack", 32'(b_ack0), 32'd0);
        end
        @(negedge clock);
        check("hold_m_en_off", 32'(b_m_en), 32'd0);
        check("hold_no_ack3", 32'(b_ack0), 32'd0);
        @(negedge clock);
        check("hold_ack", 32'(b_ack0), 32'd1);
        check("hold_rdata", b_rdata0, ref_rd(32'h100));
        check("hold_err", 32'(b_err), 32'd0);

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            logic [1:0] sel;
            sel = 2'($urandom_range(1, 3));
            for (int m = 0; m < 2; m++) begin
                if (sel[m]) set_req(m, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                                    rand_addr(), $urandom());
            end
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
